// File: rtl/tanh_pwl_pipe_if.sv
// Handshake bundle for the tanh_pwl_pipe activation unit.
//   in_data/in_mode/in_valid/in_ready    : upstream stream (MAC array side)
//   out_data/out_sat/out_valid/out_ready : downstream stream (next-layer buffer side)
//   busy                                 : any stage holds a valid sample
// master = producer/consumer environment, slave = the unit itself.
interface tanh_pwl_pipe_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_mode;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] out_data;
    logic         out_sat;
    logic         out_valid;
    logic         out_ready;
    logic         busy;

    modport master (
        output in_data, in_mode, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid, busy
    );

    modport slave (
        input  in_data, in_mode, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid, busy
    );
endinterface

// File: rtl/tanh_pwl_pipe.sv
// Three-stage pipelined piecewise-linear tanh.
//   Input  Q3.(W-3) signed, output Q1.(W-1) signed.
//   S1: sign / mode / magnitude, S2: segment evaluation, S3: rescale, mode
//   masking and sign restore (output registers).
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : tanh_pwl_pipe_if.slave (stream in, stream out, busy)
// Global stall: every stage advances only when the output register is empty
// or being drained, so in_ready depends combinationally on out_ready.
module tanh_pwl_pipe #(
    parameter int W        = 8,
    parameter int APX_DROP = 4
) (
    input  logic            clk,
    input  logic            reset,
    tanh_pwl_pipe_if.slave  bus
);

    localparam int F = W - 3;

    localparam logic [W-1:0] ONE      = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] TH_H     = ONE << (F - 1);
    localparam logic [W-1:0] TH_O     = ONE << F;
    localparam logic [W-1:0] TH_T     = ONE << (F + 1);
    localparam logic [W-1:0] OFF1     = ONE << (F - 2);
    localparam logic [W-1:0] OFF2     = (ONE << (F - 1)) + (ONE << (F - 3));
    localparam logic [W-1:0] MAG_MAX  = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] APX_MASK = ~((ONE << APX_DROP) - ONE);

    logic en;

    logic         s1_valid;
    logic         s1_sign;
    logic         s1_mode;
    logic [W-1:0] s1_mag;

    logic         s2_valid;
    logic         s2_sign;
    logic         s2_mode;
    logic         s2_sat;
    logic [W-1:0] s2_y;

    logic         s3_valid;
    logic [W-1:0] s3_data;
    logic         s3_sat;

    logic [W-1:0] in_mag;
    logic [W-1:0] seg_y;
    logic         seg_sat;
    logic [W-1:0] out_mag;
    logic [W-1:0] out_next;

    assign en           = !s3_valid || bus.out_ready;
    assign bus.in_ready = en;

    assign bus.out_valid = s3_valid;
    assign bus.out_data  = s3_data;
    assign bus.out_sat   = s3_sat;
    assign bus.busy      = s1_valid || s2_valid || s3_valid;

    // Most negative input maps to 2^(W-1), which still fits as unsigned W bits.
    assign in_mag = bus.in_data[W-1] ? (~bus.in_data + ONE) : bus.in_data;

    always_comb begin
        seg_y   = s1_mag;
        seg_sat = 1'b0;
        if (s1_mag >= TH_T) begin
            seg_y   = '0;
            seg_sat = 1'b1;
        end else if (s1_mag >= TH_O) begin
            seg_y = (s1_mag >> 3) + OFF2;
        end else if (s1_mag >= TH_H) begin
            seg_y = (s1_mag >> 1) + OFF1;
        end
    end

    // y stays below 2^F, so y << 2 never reaches the sign bit.
    always_comb begin
        out_mag = s2_sat ? MAG_MAX : (s2_y << 2);
        if (s2_mode) begin
            out_mag = out_mag & APX_MASK;
        end
        out_next = s2_sign ? (~out_mag + ONE) : out_mag;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_mode  <= 1'b0;
            s1_mag   <= '0;
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_mode  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_y     <= '0;
            s3_valid <= 1'b0;
            s3_data  <= '0;
            s3_sat   <= 1'b0;
        end else if (en) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= bus.in_data[W-1];
            s1_mode  <= bus.in_mode;
            s1_mag   <= in_mag;
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_mode  <= s1_mode;
            s2_sat   <= seg_sat;
            s2_y     <= seg_y;
            s3_valid <= s2_valid;
            s3_data  <= out_next;
            s3_sat   <= s2_sat;
        end
    end

endmodule

// File: tb/tb_tanh_pwl_pipe.sv
module tb_tanh_pwl_pipe;

    localparam int W  = 8;
    localparam int AD = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    tanh_pwl_pipe_if #(.W(W)) bus ();

    tanh_pwl_pipe #(.W(W), .APX_DROP(AD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [W-1:0] data;
        logic         sat;
        bit           has_lit;
        logic [W-1:0] lit_data;
        logic         lit_sat;
        bit           chk_lat;
        int           acc_cyc;
    } exp_t;

    typedef struct {
        logic [W-1:0] d;
        logic         m;
        logic [W-1:0] ld;
        logic         ls;
    } stim_t;

    exp_t  sb[$];
    stim_t vq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bit           in_fire  = 0;
    bit           out_fire = 0;
    bit           hold_valid = 0;
    logic [W-1:0] hold_data;
    logic         hold_sat;

    bit           cur_has_lit = 0;
    logic [W-1:0] cur_lit_data = '0;
    logic         cur_lit_sat  = 1'b0;
    bit           cur_chk_lat  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference tanh built straight from the segment definitions with integer math.
    function automatic void model(input logic [W-1:0] x, input logic mode,
                                  output logic [W-1:0] d, output logic sat);
        int v, m, f, y, mag;
        v = int'($signed(x));
        m = (v < 0) ? -v : v;
        f = 2 ** (W - 3);
        if (m >= 2 * f) begin
            sat = 1'b1;
            mag = 2 ** (W - 1) - 1;
        end else begin
            sat = 1'b0;
            if (m < f / 2)      y = m;
            else if (m < f)     y = m / 2 + f / 4;
            else                y = m / 8 + (5 * f) / 8;
            mag = y * 4;
        end
        if (mode) mag = mag - (mag % (2 ** AD));
        d = W'((v < 0) ? -mag : mag);
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] md;
        logic         ms;
        cyc++;
        in_fire  = 0;
        out_fire = 0;
        if (!reset) begin
            check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
            check("busy_vs_inflight", bus.busy, sb.size() != 0);
            if (hold_valid) begin
                check("stall_hold_data", bus.out_data, hold_data);
                check("stall_hold_sat", bus.out_sat, hold_sat);
                check("stall_hold_valid", bus.out_valid, 1'b1);
            end
            hold_valid = bus.out_valid && !bus.out_ready;
            hold_data  = bus.out_data;
            hold_sat   = bus.out_sat;

            out_fire = bus.out_valid && bus.out_ready;
            if (bus.out_valid && sb.size() == 0) begin
                check("stale_output", bus.out_valid, 1'b0);
            end else if (out_fire) begin
                e = sb.pop_front();
                check("out_data_model", bus.out_data, e.data);
                check("out_sat_model", bus.out_sat, e.sat);
                if (e.has_lit) begin
                    check("out_data_literal", bus.out_data, e.lit_data);
                    check("out_sat_literal", bus.out_sat, e.lit_sat);
                end
                if (e.chk_lat) check("latency", cyc - e.acc_cyc, 3);
            end

            in_fire = bus.in_valid && bus.in_ready;
            if (in_fire) begin
                model(bus.in_data, bus.in_mode, md, ms);
                e.data     = md;
                e.sat      = ms;
                e.has_lit  = cur_has_lit;
                e.lit_data = cur_lit_data;
                e.lit_sat  = cur_lit_sat;
                e.chk_lat  = cur_chk_lat;
                e.acc_cyc  = cyc;
                sb.push_back(e);
            end
        end else begin
            hold_valid = 0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [W-1:0] d, input logic m, input logic [W-1:0] ld, input logic ls);
        stim_t s;
        logic [W-1:0] md;
        logic         ms;
        model(d, m, md, ms);
        check("model_pin_data", md, ld);
        check("model_pin_sat", ms, ls);
        s.d = d; s.m = m; s.ld = ld; s.ls = ls;
        vq.push_back(s);
    endtask

    task automatic drain();
        int g = 0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        while (sb.size() != 0 && g < 100) begin
            tick();
            g++;
        end
        check("drain_remaining", sb.size(), 0);
        tick();
        check("drain_busy", bus.busy, 1'b0);
    endtask

    // Stream the queued vectors; out_ready is dropped for cycle indices [stall_lo, stall_hi).
    task automatic run_stream(input int stall_lo, input int stall_hi, input bit lat);
        int i = 0;
        while (vq.size() != 0 && i < 200) begin
            bus.in_valid  = 1'b1;
            bus.in_data   = vq[0].d;
            bus.in_mode   = vq[0].m;
            cur_has_lit   = 1;
            cur_lit_data  = vq[0].ld;
            cur_lit_sat   = vq[0].ls;
            cur_chk_lat   = lat;
            bus.out_ready = !(i >= stall_lo && i < stall_hi);
            tick();
            if (in_fire) void'(vq.pop_front());
            i++;
        end
        check("stream_all_accepted", vq.size(), 0);
        vq.delete();
        cur_has_lit = 0;
        cur_chk_lat = 0;
        drain();
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int g;

        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b1;

        #12;
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_data", bus.out_data, 8'h00);
        check("rst_out_sat", bus.out_sat, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        tick();
        reset = 1'b0;
        tick();

        // Precise mode, back-to-back, unstalled: latency 3.
        add(8'h08, 1'b0, 8'h20, 1'b0);
        add(8'h10, 1'b0, 8'h40, 1'b0);
        add(8'h20, 1'b0, 8'h60, 1'b0);
        add(8'h30, 1'b0, 8'h68, 1'b0);
        run_stream(1000, 1000, 1);

        // Saturation, sign and segment edges.
        add(8'h40, 1'b0, 8'h7F, 1'b1);
        add(8'h7F, 1'b0, 8'h7F, 1'b1);
        add(8'h80, 1'b0, 8'h81, 1'b1);
        add(8'hF0, 1'b0, 8'hC0, 1'b0);
        add(8'h00, 1'b0, 8'h00, 1'b0);
        add(8'h0F, 1'b0, 8'h3C, 1'b0);
        add(8'h1F, 1'b0, 8'h5C, 1'b0);
        add(8'h3F, 1'b0, 8'h6C, 1'b0);
        add(8'hC0, 1'b0, 8'h81, 1'b1);
        add(8'hE0, 1'b0, 8'hA0, 1'b0);
        run_stream(1000, 1000, 0);

        // Approximate mode.
        add(8'h05, 1'b1, 8'h10, 1'b0);
        add(8'h30, 1'b1, 8'h60, 1'b0);
        add(8'h40, 1'b1, 8'h70, 1'b1);
        add(8'hFB, 1'b1, 8'hF0, 1'b0);
        run_stream(1000, 1000, 0);

        // Backpressure: out_ready low for 4 cycles once outputs are flowing.
        add(8'h08, 1'b0, 8'h20, 1'b0);
        add(8'h10, 1'b0, 8'h40, 1'b0);
        add(8'h20, 1'b0, 8'h60, 1'b0);
        add(8'h30, 1'b0, 8'h68, 1'b0);
        add(8'hF0, 1'b0, 8'hC0, 1'b0);
        add(8'h40, 1'b0, 8'h7F, 1'b1);
        run_stream(4, 8, 0);

        // Reset with three samples in flight.
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.in_data = W'(8'h10 + k);
            bus.in_mode = 1'b0;
            tick();
        end
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", bus.out_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_out_data", bus.out_data, 8'h00);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("post_rst_no_output", bus.out_valid, 1'b0);
        end
        check("post_rst_in_ready", bus.in_ready, 1'b1);

        // Random stress with random valid/ready.
        acc = 0;
        g   = 0;
        bus.in_valid = 1'b0;
        while (acc < 10000 && g < 60000) begin
            if (!bus.in_valid || in_fire) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_data  = W'($urandom);
                bus.in_mode  = 1'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (in_fire) acc++;
            g++;
        end
        check("stress_accepted", acc, 10000);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tanh_pwl_pipe.md
Name: tanh_pwl_pipe

Overview:
- Parametrised, pipelined tanh activation unit; successor to the fixed 4-bit combinational tanh approximators in the activation-function library.
- Evaluates a four-segment power-of-two-slope piecewise-linear tanh on a signed fixed-point stream.
- Runtime-selectable precise/approximate output mode.
- valid/ready handshake on both sides; sits between a MAC array output and the next layer's input buffer.

Parameters:
- W, 8: data width of input and output; legal W >= 6.
- APX_DROP, 4: output magnitude LSBs forced to zero in approximate mode; legal 0..W-2.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  W  signed two's complement, Q3.(W-3) (F = W-3 fractional bits).
- in_mode  input  1  0 = precise, 1 = approximate; sampled with in_data.
- in_valid  input  1  in_data/in_mode valid.
- in_ready  output  1  unit accepts input this cycle.
- out_data  output  W  signed two's complement, Q1.(W-1).
- out_sat  output  1  sample was in saturation region (|x| >= 2.0).
- out_valid  output  1  out_data/out_sat valid.
- out_ready  input  1  downstream accepts output.
- busy  output  1  OR of all stage valid bits.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - out_data = 0, out_sat = 0, out_valid = 0, busy = 0.
  - All internal stage valid bits = 0; data registers = 0.
  - in_ready = 1 out of reset (follows from the stall rule below).
- Pipeline: 3 register stages, S1, S2, S3 = output registers. Latency 3 cycles from accepting handshake to out_valid when unstalled. Throughput 1 sample/cycle.
- Stall rule:
  - en = !out_valid | out_ready; in_ready = en.
  - All stages advance only when en = 1; global stall, no bubbles collapsed.
  - Combinational out_ready -> in_ready path is permitted.
- Transfers: input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
- Valid propagation: while en = 1, S1 valid <= in_valid, each later stage takes the prior valid. Data in registers with valid = 0 is don't-care. out_data/out_sat hold stable while out_valid & !out_ready.
- S1: register sign s = in_data[W-1], mode, and magnitude m = |in_data| as W-bit unsigned. -2^(W-1) gives m = 2^(W-1), no overflow.
- S2: segment on m, F fractional bits, thresholds H = 1<<(F-1), O = 1<<F, T = 2<<F:
  - m < H: y = m.
  - H <= m < O: y = (m>>1) + (1<<(F-2)).
  - O <= m < T: y = (m>>3) + 5*(1<<(F-3)).
  - m >= T: saturate, sat = 1.
  - Shifts truncate.
- S3 output:
  - Non-saturated: mag = y << 2 (rescale F to W-1 fractional bits).
  - Saturated: mag = 2^(W-1)-1.
  - If mode = 1, zero the low APX_DROP bits of mag.
  - out_data = s ? -mag : mag; out_sat = sat.
  - Zero input gives 0 regardless of sign path; there is no negative zero.
- Continuity: segments meet exactly at 0.5 and 1.0. The jump at 2.0 (0.875 to max) is intended.
- Reset mid-operation: all in-flight samples are discarded, outputs return to reset values immediately (asynchronous), no partial output after release.
- Simultaneous input accept and output accept under en = 1 is legal and sustains full throughput.

Test Plan (W=8, APX_DROP=4):
- Reset asserted mid-stream with 3 samples in flight -> out_valid=0, busy=0 immediately; after release, no stale output; in_ready=1.
- Precise mode, back-to-back in_data = 0x08, 0x10, 0x20, 0x30, out_ready=1 -> out_data = 0x20, 0x40, 0x60, 0x68 on cycles 3..6 after first accept; out_sat=0.
- Saturation/sign: in_data = 0x40, 0x7F, 0x80, 0xF0, 0x00 -> out_data = 0x7F, 0x7F, 0x81, 0xC0, 0x00; out_sat = 1, 1, 1, 0, 0.
- Approximate mode: in_data = 0x05, 0x30, 0x40 with in_mode=1 -> out_data = 0x10, 0x60, 0x70.
- Backpressure: stream 6 samples, hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 while out_valid & !out_ready; out_data stable; all 6 results delivered in order, none lost or duplicated.
- Random stress: random in_valid/out_ready, 10k samples -> scoreboard against the segment model bit-exact; busy=0 only when pipeline empty.
